// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller: opcodes, FSM states,
// accumulator shift-mode encodings and the registered control-output bundle.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_DIV = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_CLR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef struct packed {
    logic       ah_inen;
    logic       s_add;
    logic       s_sub;
    logic       s_and;
    logic       s_mul;
    logic       s_div;
    logic       acc_clr;
    logic       acc_oen;
    logic [1:0] hs;
    logic [1:0] ls;
    logic       done;
    logic       ill_op;
    logic       div_err;
  } ctrl_out_t;

  // Counter width able to hold ITER-1 (never narrower than one bit).
  function automatic int cnt_width(input int iter);
    return (iter > 32'sd2) ? $clog2(iter) : 32'sd1;
  endfunction

  // MUL always iterates; DIV iterates only when the divisor is non-zero.
  function automatic logic is_iter_op(input logic [3:0] op, input logic bz);
    return (op == OP_MUL) || ((op == OP_DIV) && !bz);
  endfunction

endpackage

// File: rtl/alu_ctrl_cnt.sv
// Loadable iteration down-counter; saturates at zero and reports zero / one.
module alu_ctrl_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] count_r;

  // Count register: clear, load on acceptance, decrement without wrap.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});
  assign one  = (count_r == W'(1'b1));

endmodule

// File: rtl/alu_ctrl.sv
// ALU sequencing controller: accepts opcodes while idle and issues registered
// datapath strobes, multi-cycle MUL/DIV iteration and status flag capture.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ITER = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       op_valid,
  input  logic [3:0] op_code,
  input  logic       breg_zero,
  input  logic       zero_flag,
  input  logic       sign_flag,
  output logic       op_ready,
  output logic       busy,
  output logic       done,
  output logic       ill_op,
  output logic       div_err,
  output logic       ah_inen,
  output logic       s_add,
  output logic       s_sub,
  output logic       s_and,
  output logic       s_mul,
  output logic       s_div,
  output logic       acc_clr,
  output logic       acc_oen,
  output logic [1:0] hs,
  output logic [1:0] ls,
  output logic       flag_z,
  output logic       flag_n
);

  localparam int CNT_W = cnt_width(ITER);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 32'sd1);

  state_t     state_r, state_next_s;
  logic [3:0] op_r, op_sel_s;
  logic       accept_s, cnt_load_s, cnt_dec_s, cnt_zero_s, cnt_one_s, last_iter_s;
  logic       op_ready_r, flag_z_r, flag_n_r;
  ctrl_out_t  out_next_s, out_r;

  assign accept_s    = (state_r == ST_IDLE) && op_valid;
  assign cnt_load_s  = accept_s && is_iter_op(op_code, breg_zero);
  assign cnt_dec_s   = (state_r == ST_ITER) && !cnt_zero_s;
  // The iteration cycle about to be entered is the last one when the count it sees is zero.
  assign last_iter_s = (state_r == ST_IDLE) ? (CNT_LOAD == {CNT_W{1'b0}}) : cnt_one_s;

  alu_ctrl_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load_s),
    .dec      (cnt_dec_s),
    .load_val (CNT_LOAD),
    .zero     (cnt_zero_s),
    .one      (cnt_one_s)
  );

  // State register and opcode latch.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_IDLE;
      op_r    <= OP_NOP;
    end else begin
      state_r <= state_next_s;
      op_r    <= accept_s ? op_code : op_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = is_iter_op(op_code, breg_zero) ? ST_ITER : ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_IDLE;
      ST_ITER: begin
        if (cnt_zero_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ITER;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  assign op_sel_s = accept_s ? op_code : op_r;

  // Output decode for the cycle being entered; registered below.
  always_comb begin
    out_next_s = '0;
    case (state_next_s)
      ST_EXEC: begin
        out_next_s.done = 1'b1;
        case (op_sel_s)
          OP_NOP, OP_MUL: out_next_s.done = 1'b1;
          OP_LDA: begin
            out_next_s.ah_inen = 1'b1;
            out_next_s.hs      = MODE_LOAD;
            out_next_s.ls      = MODE_LOAD;
          end
          OP_ADD: begin
            out_next_s.s_add = 1'b1;
            out_next_s.hs    = MODE_LOAD;
          end
          OP_SUB: begin
            out_next_s.s_sub = 1'b1;
            out_next_s.hs    = MODE_LOAD;
          end
          OP_AND: begin
            out_next_s.s_and = 1'b1;
            out_next_s.hs    = MODE_LOAD;
          end
          OP_DIV:  out_next_s.div_err = 1'b1;  // DIV only reaches EXEC on a zero divisor
          OP_OUT:  out_next_s.acc_oen = 1'b1;
          OP_CLR:  out_next_s.acc_clr = 1'b1;
          OP_SHL: begin
            out_next_s.hs = MODE_SHL;
            out_next_s.ls = MODE_SHL;
          end
          OP_SHR: begin
            out_next_s.hs = MODE_SHR;
            out_next_s.ls = MODE_SHR;
          end
          default: out_next_s.ill_op = 1'b1;
        endcase
      end
      ST_ITER: begin
        out_next_s.done = last_iter_s;
        if (op_sel_s == OP_MUL) begin
          out_next_s.s_mul = 1'b1;
          out_next_s.hs    = MODE_SHR;
          out_next_s.ls    = MODE_SHR;
        end else begin
          out_next_s.s_div = 1'b1;
          out_next_s.hs    = MODE_SHL;
          out_next_s.ls    = MODE_SHL;
        end
      end
      default: out_next_s = '0;
    endcase
  end

  // Output, ready and status flag registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      out_r      <= '0;
      op_ready_r <= 1'b1;
      flag_z_r   <= 1'b0;
      flag_n_r   <= 1'b0;
    end else begin
      out_r      <= out_next_s;
      op_ready_r <= (state_next_s == ST_IDLE);
      flag_z_r   <= out_r.done ? zero_flag : flag_z_r;
      flag_n_r   <= out_r.done ? sign_flag : flag_n_r;
    end
  end

  assign op_ready = op_ready_r;
  assign busy     = ~op_ready_r;
  assign done     = out_r.done;
  assign ill_op   = out_r.ill_op;
  assign div_err  = out_r.div_err;
  assign ah_inen  = out_r.ah_inen;
  assign s_add    = out_r.s_add;
  assign s_sub    = out_r.s_sub;
  assign s_and    = out_r.s_and;
  assign s_mul    = out_r.s_mul;
  assign s_div    = out_r.s_div;
  assign acc_clr  = out_r.acc_clr;
  assign acc_oen  = out_r.acc_oen;
  assign hs       = out_r.hs;
  assign ls       = out_r.ls;
  assign flag_z   = flag_z_r;
  assign flag_n   = flag_n_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed scenarios followed by random
// opcode traffic, compared cycle by cycle against a per-opcode reference table.
module tb_alu_ctrl;

  localparam int ITER = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       op_valid = 1'b0;
  logic [3:0] op_code = 4'h0;
  logic       breg_zero = 1'b0;
  logic       zero_flag = 1'b0;
  logic       sign_flag = 1'b0;
  logic       op_ready, busy, done, ill_op, div_err;
  logic       ah_inen, s_add, s_sub, s_and, s_mul, s_div, acc_clr, acc_oen;
  logic [1:0] hs, ls;
  logic       flag_z, flag_n;

  int   checks = 0;
  int   errors = 0;
  logic fz_m = 1'b0;
  logic fn_m = 1'b0;

  alu_ctrl #(.ITER(ITER)) dut (
    .clk(clk), .clr(clr), .op_valid(op_valid), .op_code(op_code),
    .breg_zero(breg_zero), .zero_flag(zero_flag), .sign_flag(sign_flag),
    .op_ready(op_ready), .busy(busy), .done(done), .ill_op(ill_op),
    .div_err(div_err), .ah_inen(ah_inen), .s_add(s_add), .s_sub(s_sub),
    .s_and(s_and), .s_mul(s_mul), .s_div(s_div), .acc_clr(acc_clr),
    .acc_oen(acc_oen), .hs(hs), .ls(ls), .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {ah_inen, s_add, s_sub, s_and, s_mul, s_div, acc_clr, acc_oen, hs, ls}
  function automatic logic [11:0] obs_vec();
    return {ah_inen, s_add, s_sub, s_and, s_mul, s_div, acc_clr, acc_oen, hs, ls};
  endfunction

  // Reference: what an opcode asks of the datapath and how long it lasts.
  task automatic model(input logic [3:0] op, input logic bz, output int len,
                       output logic [11:0] ev, output logic ill, output logic dz);
    len = 1; ill = 1'b0; dz = 1'b0;
    case (op)
      4'h1: ev = {8'b1000_0000, 2'b11, 2'b11};
      4'h2: ev = {8'b0100_0000, 2'b11, 2'b00};
      4'h3: ev = {8'b0010_0000, 2'b11, 2'b00};
      4'h4: ev = {8'b0001_0000, 2'b11, 2'b00};
      4'h5: begin ev = {8'b0000_1000, 2'b01, 2'b01}; len = ITER; end
      4'h6: begin
        if (bz) begin ev = 12'h000; dz = 1'b1; end
        else begin ev = {8'b0000_0100, 2'b10, 2'b10}; len = ITER; end
      end
      4'h7: ev = {8'b0000_0001, 2'b00, 2'b00};
      4'h8: ev = {8'b0000_0010, 2'b00, 2'b00};
      4'h9: ev = {8'b0000_0000, 2'b10, 2'b10};
      4'hA: ev = {8'b0000_0000, 2'b01, 2'b01};
      4'h0: ev = 12'h000;
      default: begin ev = 12'h000; ill = 1'b1; end
    endcase
  endtask

  // Offer one opcode in the current idle cycle and check every cycle until idle again.
  task automatic run_op(input logic [3:0] op, input logic bz, input logic hold, input logic zf_one);
    int len;
    logic [11:0] ev;
    logic ill, dz, zf, sf;
    model(op, bz, len, ev, ill, dz);
    op_valid = 1'b1; op_code = op; breg_zero = bz;
    tick();
    for (int k = 1; k <= len; k++) begin
      chk($sformatf("strobes op%h c%0d", op, k), {4'h0, obs_vec()}, {4'h0, ev});
      chk($sformatf("done op%h c%0d", op, k), {15'h0, done}, {15'h0, (k == len)});
      chk($sformatf("ill_op op%h c%0d", op, k), {15'h0, ill_op}, {15'h0, (k == len) && ill});
      chk($sformatf("div_err op%h c%0d", op, k), {15'h0, div_err}, {15'h0, (k == len) && dz});
      chk($sformatf("busy op%h c%0d", op, k), {14'h0, op_ready, busy}, 16'h0001);
      chk($sformatf("flag_hold op%h c%0d", op, k), {14'h0, flag_z, flag_n}, {14'h0, fz_m, fn_m});
      zf = zf_one ? 1'b1 : 1'($urandom_range(0, 1));
      sf = 1'($urandom_range(0, 1));
      zero_flag = zf; sign_flag = sf;
      if (!hold) begin
        op_valid  = 1'($urandom_range(0, 1));
        op_code   = 4'($urandom_range(0, 15));
        breg_zero = 1'($urandom_range(0, 1));
      end
      if (k == len) begin fz_m = zf; fn_m = sf; end
      tick();
    end
    chk($sformatf("idle_out op%h", op), {1'b0, obs_vec(), done, ill_op, div_err}, 16'h0000);
    chk($sformatf("ready op%h", op), {14'h0, op_ready, busy}, 16'h0002);
    chk($sformatf("flags op%h", op), {14'h0, flag_z, flag_n}, {14'h0, fz_m, fn_m});
    if (!hold) op_valid = 1'b0;
  endtask

  initial begin
    // Reset, with an opcode offered so clear must win over acceptance.
    clr = 1'b1; op_valid = 1'b1; op_code = 4'h2;
    tick(); tick();
    chk("reset_out", {1'b0, obs_vec(), done, ill_op, div_err}, 16'h0000);
    chk("reset_flags", {14'h0, flag_z, flag_n}, 16'h0000);
    clr = 1'b0; op_valid = 1'b0;
    chk("reset_ready", {14'h0, op_ready, busy}, 16'h0002);
    tick();
    chk("post_reset_ready", {14'h0, op_ready, busy}, 16'h0002);

    // Directed: ADD, MUL, DIV by zero, illegal F, OUT, DIV, LDA, shifts, CLR, NOP.
    run_op(4'h2, 1'b0, 1'b0, 1'b0);
    run_op(4'h5, 1'b0, 1'b0, 1'b0);
    run_op(4'h6, 1'b1, 1'b0, 1'b0);
    run_op(4'hF, 1'b0, 1'b0, 1'b0);
    run_op(4'h7, 1'b0, 1'b0, 1'b0);
    run_op(4'h6, 1'b0, 1'b0, 1'b0);
    run_op(4'h1, 1'b0, 1'b0, 1'b0);
    run_op(4'h9, 1'b0, 1'b0, 1'b0);
    run_op(4'hA, 1'b0, 1'b0, 1'b0);
    run_op(4'h8, 1'b0, 1'b0, 1'b0);
    run_op(4'h0, 1'b0, 1'b0, 1'b0);

    // Clear during the second MUL cycle.
    op_valid = 1'b1; op_code = 4'h5; breg_zero = 1'b0;
    tick();
    op_valid = 1'b0;
    chk("clrmul_c1", {4'h0, obs_vec()}, {4'h0, 8'b0000_1000, 2'b01, 2'b01});
    tick();
    chk("clrmul_c2", {4'h0, obs_vec()}, {4'h0, 8'b0000_1000, 2'b01, 2'b01});
    clr = 1'b1;
    tick();
    clr = 1'b0; fz_m = 1'b0; fn_m = 1'b0;
    chk("clrmul_out", {1'b0, obs_vec(), done, ill_op, div_err}, 16'h0000);
    chk("clrmul_flags", {14'h0, flag_z, flag_n}, 16'h0000);
    chk("clrmul_ready", {14'h0, op_ready, busy}, 16'h0002);
    tick();
    chk("clrmul_nodone", {14'h0, done, op_ready}, 16'h0001);

    // Back-to-back SUB with op_valid held; zero_flag high in each done cycle.
    for (int i = 0; i < 3; i++) run_op(4'h3, 1'b0, 1'b1, 1'b1);
    op_valid = 1'b0;
    tick();
    chk("b2b_flag_z", {15'h0, flag_z}, 16'h0001);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter ITER, default 4, number of MUL/DIV iteration cycles (equals datapath nibble width).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 op_valid  input  1  opcode offered this cycle.
REQ-005 op_code  input  4  opcode; meaningful only while op_valid=1.
REQ-006 breg_zero  input  1  B register equals 0; sampled at opcode acceptance.
REQ-007 zero_flag, sign_flag  input  1 each  datapath result flags.
REQ-008 op_ready  output  1  controller idle and able to accept an opcode.
REQ-009 busy  output  1  operation in progress (inverse of op_ready).
REQ-010 done  output  1  one-cycle pulse on the last strobe cycle of an operation.
REQ-011 ill_op, div_err  output  1 each  one-cycle pulses coincident with done.
REQ-012 ah_inen, s_add, s_sub, s_and, s_mul, s_div, acc_clr, acc_oen  output  1 each  datapath strobes.
REQ-013 hs, ls  output  2 each  accumulator high/low shift mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-014 flag_z, flag_n  output  1 each  registered status flags.

Function
REQ-015 Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 AND, 5 MUL, 6 DIV, 7 OUT, 8 CLR, 9 SHL, A SHR; B-F illegal.
REQ-016 States: IDLE, EXEC, ITER; op_ready=1 only in IDLE.
REQ-017 Acceptance: op_valid=1 and op_ready=1 at edge T; op_code is latched, and op_valid is ignored outside IDLE.
REQ-018 All strobes, hs, ls, done, ill_op and div_err are registered; they are 0/00 in IDLE.
REQ-019 Single-cycle ops: EXEC at T+1 with the strobe set and done=1; IDLE and op_ready=1 at T+2.
REQ-020 Strobe sets: LDA ah_inen, hs=ls=11; ADD s_add, hs=11; SUB s_sub, hs=11; AND s_and, hs=11; OUT acc_oen; CLR acc_clr; SHL hs=ls=10; SHR hs=ls=01; NOP none.
REQ-021 MUL: ITER state for ITER cycles T+1..T+ITER, each with s_mul=1 and hs=ls=01; done=1 on cycle T+ITER only.
REQ-022 DIV: ITER state for ITER cycles, each with s_div=1 and hs=ls=10; done=1 on the last cycle.
REQ-023 Iteration counter loads ITER-1 at acceptance, decrements per ITER cycle, and exits to IDLE after the cycle in which it is 0; there is no wrap-around.
REQ-024 DIV with breg_zero=1 at acceptance: goes to EXEC for one cycle with no strobes, done=1 and div_err=1.
REQ-025 Illegal opcode: behaves as NOP, with ill_op=1 alongside done.
REQ-026 Exactly one of s_add, s_sub, s_and, s_mul, s_div is high in any cycle, or none.
REQ-027 flag_z and flag_n load zero_flag and sign_flag sampled in the done cycle; they update on the following edge and otherwise hold.
REQ-028 op_valid=1 arriving in the same cycle as done is not accepted until op_ready=1, at T+2 for single-cycle ops.

Reset
REQ-029 clr=1 at any edge, including mid-MUL/DIV, forces IDLE, all outputs 0/00, flag_z=0, flag_n=0 and counter 0, and it wins over acceptance.
REQ-030 op_ready=1 in the first cycle after clr deasserts.

Structure
REQ-031 Shared package alu_ctrl_pkg holds the opcode constants, the state enum and the hs/ls mode encodings.
REQ-032 One sub-module, alu_ctrl_cnt, implements the loadable down-counter with a zero flag; the FSM and output decode reside in alu_ctrl.

Verification
REQ-033 After reset, ADD offered at T -> s_add=1, hs=11, done=1 at T+1; op_ready=1 at T+2; other strobes 0.
REQ-034 MUL with ITER=4 -> s_mul=1, hs=ls=01 for exactly 4 cycles; done only on the 4th; busy=1 throughout.
REQ-035 DIV with breg_zero=1 -> one cycle with done=1 and div_err=1, s_div never asserted.
REQ-036 op_code=F -> done=1 with ill_op=1, no strobes; op_code=7 -> acc_oen=1 for one cycle.
REQ-037 clr=1 during the 2nd MUL cycle -> all outputs 0 next cycle, op_ready=1 after release, no done pulse.
REQ-038 Back-to-back: SUB held valid continuously -> accepted every 2 cycles; zero_flag=1 at done -> flag_z=1 next cycle.
